// File: rtl/stream_dup_map_n.sv
// ============================================================================
// stream_dup_map_n : fans one valid/ready stream out to CHANNELS FIFO-buffered
//                    outputs, channel k emitting x + (k+1)*STEP.
// Revision 1.0
// ============================================================================
`default_nettype none

module stream_dup_map_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2,
  parameter int STEP     = 1,
  parameter int LENGTH   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic [WIDTH-1:0]            sIn,
  input  logic                        sIn_valid,
  output logic                        sIn_ready,
  output logic [CHANNELS*WIDTH-1:0]   sOut,
  output logic [CHANNELS-1:0]         sOut_valid,
  input  logic [CHANNELS-1:0]         sOut_ready
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (LENGTH > 0) ? $clog2(LENGTH + 1) : 1;

  localparam logic [CNTW-1:0] FULL_C = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_C = CW'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [CHANNELS-1:0]  full;
  logic                 accept;
  logic                 all_empty;
  logic                 last_item;

  // Readiness looks only at registered state and counts, never at sIn_valid.
  assign sIn_ready = (state_q == S_RUN) && !(|full);
  assign accept    = sIn_valid && sIn_ready;
  assign all_empty = ~|sOut_valid;
  assign last_item = (LENGTH != 0) && (cnt_q == LAST_C);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_item) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (all_empty) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'((k + 1) * STEP);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             pop;
    logic             nonempty;

    assign nonempty      = (count_q != '0);
    assign pop           = nonempty && sOut_ready[k];
    assign full[k]       = (count_q == FULL_C);
    assign sOut_valid[k] = nonempty;
    // An empty FIFO shows zero so stale entries never leak onto the bus.
    assign sOut[k*WIDTH +: WIDTH] = nonempty ? mem_q[rptr_q] : '0;

    always_comb begin
      count_d = count_q;
      case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (accept) begin
        mem_q[wptr_q] <= sIn + OFFSET;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        count_q <= count_d;
        if (accept) begin
          wptr_q <= wptr_q + 1'b1;
        end
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_dup_map_n.sv
// ============================================================================
// tb_stream_dup_map_n : checks a free-running and a bounded (LENGTH=3) instance
//                       against a queue-based model plus directed literals.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stream_dup_map_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;
  logic [1:0]  sIn_valid;
  logic [7:0]  sIn        [2];
  logic [1:0]  sOut_ready [2];
  wire  [1:0]  in_ready;
  wire  [1:0]  out_valid;
  wire  [1:0]  sIn_ready;
  wire  [15:0] sOut       [2];
  wire  [1:0]  sOut_valid [2];

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(2), .DEPTH(2), .STEP(1), .LENGTH(0)) u_free (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sIn(sIn[0]), .sIn_valid(sIn_valid[0]), .sIn_ready(sIn_ready[0]),
    .sOut(sOut[0]), .sOut_valid(sOut_valid[0]), .sOut_ready(sOut_ready[0])
  );

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(2), .DEPTH(2), .STEP(1), .LENGTH(3)) u_bound (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sIn(sIn[1]), .sIn_valid(sIn_valid[1]), .sIn_ready(sIn_ready[1]),
    .sOut(sOut[1]), .sOut_valid(sOut_valid[1]), .sOut_ready(sOut_ready[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 running, 2 draining, 3 done; one queue per (instance, channel).
  int         ms [2];
  int         mc [2];
  logic [7:0] mq [4][$];
  bit         m_acc;
  bit         m_empty;
  int         m_lim;
  logic [7:0] m_val;

  function automatic bit m_rdy(input int i);
    return (ms[i] == 1) && (mq[2*i].size() < 2) && (mq[2*i+1].size() < 2);
  endfunction

  initial begin
    ms[0] = 0; ms[1] = 0; mc[0] = 0; mc[1] = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        m_lim = (i == 0) ? 0 : 3;
        if (rst) begin
          ms[i] = 0;
          mc[i] = 0;
          mq[2*i].delete();
          mq[2*i+1].delete();
        end else begin
          m_acc   = sIn_valid[i] && m_rdy(i);
          m_empty = (mq[2*i].size() == 0) && (mq[2*i+1].size() == 0);
          for (int k = 0; k < 2; k++) begin
            if (mq[2*i+k].size() > 0 && sOut_ready[i][k]) void'(mq[2*i+k].pop_front());
            if (m_acc) begin
              m_val = sIn[i] + 8'(k + 1);
              mq[2*i+k].push_back(m_val);
            end
          end
          case (ms[i])
            0: if (in_valid[i]) begin ms[i] = 1; mc[i] = 0; end
            1: if (m_acc) begin
                 mc[i]++;
                 if (m_lim != 0 && mc[i] == m_lim) ms[i] = 2;
               end
            2: if (m_empty) ms[i] = 3;
            default: if (out_ready[i]) ms[i] = 0;
          endcase
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          chk("m_in_ready", i, 32'(in_ready[i]), 32'(ms[i] == 0));
          chk("m_out_valid", i, 32'(out_valid[i]), 32'(ms[i] == 3));
          chk("m_sIn_ready", i, 32'(sIn_ready[i]), 32'(m_rdy(i)));
          for (int k = 0; k < 2; k++) begin
            chk("m_sOut_valid", 2*i+k, 32'(sOut_valid[i][k]), 32'(mq[2*i+k].size() > 0));
            chk("m_sOut", 2*i+k, 32'(sOut[i][8*k +: 8]),
                (mq[2*i+k].size() > 0) ? 32'(mq[2*i+k][0]) : 32'd0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc_seen;

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = '0; sIn_valid = '0;
    sIn[0] = '0; sIn[1] = '0; sOut_ready[0] = '0; sOut_ready[1] = '0;
    step(); step();
    chk("rst_in_ready", 0, 32'(in_ready), 32'h3);
    chk("rst_sIn_ready", 0, 32'(sIn_ready), 32'h0);
    chk("rst_sOut", 0, 32'(sOut[0]), 32'h0);
    rst = 1'b0;

    // Free run: one item per cycle through both channels.
    in_valid[0] = 1'b1; step(); in_valid[0] = 1'b0;
    sOut_ready[0] = 2'b11;
    for (int j = 0; j < 6; j++) begin
      sIn[0] = 8'(j); sIn_valid[0] = 1'b1; step();
      chk("free_ch0", j, 32'(sOut[0][7:0]), 32'(j + 1));
      chk("free_ch1", j, 32'(sOut[0][15:8]), 32'(j + 2));
      chk("free_rdy", j, 32'(sIn_ready[0]), 32'h1);
    end

    // Wrap-around of the map.
    sIn[0] = 8'hFF; step();
    chk("wrap_ch0", 0, 32'(sOut[0][7:0]), 32'h00);
    chk("wrap_ch1", 0, 32'(sOut[0][15:8]), 32'h01);
    sIn_valid[0] = 1'b0; step();

    // Back-pressure on channel 1 only.
    sOut_ready[0] = 2'b01; sIn[0] = 8'd0; sIn_valid[0] = 1'b1; step();
    chk("bp_rdy1", 0, 32'(sIn_ready[0]), 32'h1);
    sIn[0] = 8'd1; step();
    chk("bp_stall", 0, 32'(sIn_ready[0]), 32'h0);
    sIn[0] = 8'd2; step();
    chk("bp_valid", 0, 32'(sOut_valid[0]), 32'h2);
    chk("bp_stall2", 0, 32'(sIn_ready[0]), 32'h0);
    chk("bp_head1", 0, 32'(sOut[0][15:8]), 32'h2);
    sOut_ready[0] = 2'b11; step();
    chk("bp_next1", 0, 32'(sOut[0][15:8]), 32'h3);
    chk("bp_resume", 0, 32'(sIn_ready[0]), 32'h1);
    step();
    chk("bp_ch0", 0, 32'(sOut[0][7:0]), 32'h3);
    chk("bp_ch1", 0, 32'(sOut[0][15:8]), 32'h4);
    sIn_valid[0] = 1'b0; step(); step();

    // Bounded run of three items.
    in_valid[1] = 1'b1; step(); in_valid[1] = 1'b0;
    sOut_ready[1] = 2'b11;
    chk("b_run", 1, 32'(in_ready[1]), 32'h0);
    acc_seen = 0;
    for (int j = 0; j < 6; j++) begin
      sIn[1] = 8'(10 + j); sIn_valid[1] = 1'b1;
      if (sIn_ready[1]) acc_seen++;
      step();
    end
    chk("b_accepts", 1, 32'(acc_seen), 32'd3);
    chk("b_done", 1, 32'(out_valid[1]), 32'h1);
    sIn_valid[1] = 1'b0; step(); step();
    chk("b_hold", 1, 32'(out_valid[1]), 32'h1);
    out_ready[1] = 1'b1; step();
    chk("b_idle", 1, 32'(in_ready[1]), 32'h1);
    chk("b_ack", 1, 32'(out_valid[1]), 32'h0);
    out_ready[1] = 1'b0; step();

    // Reset with items buffered in the free-running instance.
    sOut_ready[0] = 2'b00; sIn_valid[0] = 1'b1; sIn[0] = 8'h50; step();
    sIn[0] = 8'h51; step();
    sIn_valid[0] = 1'b0;
    chk("r_full", 0, 32'(sOut_valid[0]), 32'h3);
    chk("r_blocked", 0, 32'(sIn_ready[0]), 32'h0);
    rst = 1'b1; step();
    chk("r_valid", 0, 32'(sOut_valid[0]), 32'h0);
    chk("r_rdy", 0, 32'(sIn_ready[0]), 32'h0);
    chk("r_inr", 0, 32'(in_ready[0]), 32'h1);
    chk("r_dat", 0, 32'(sOut[0]), 32'h0);
    rst = 1'b0; sOut_ready[0] = 2'b11; step(); step();
    chk("r_stale", 0, 32'(sOut_valid[0]), 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
